ahb_multi_bridge: RTL and testbench

Parametrised AHB-to-peripheral bridge that decodes up to `N_SLV` register windows and drives a wait-state-capable, APB-style peripheral port. It supersedes the single-window bridge. It adds configurable data width, window size and slave count, plus peripheral back-pressure (`p_ready`), per-slave error, a wait-state timeout and a protocol-correct two-cycle AHB ERROR response. It sits between the AHB interconnect and a group of peripheral register files.

---
 rtl/ahb_multi_bridge.sv | 192 +++++++++++++++++++
 tb/tb_ahb_multi_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_multi_bridge.sv
// AHB-to-peripheral bridge: decodes N_SLV register windows onto a wait-state-capable,
// APB-style port, with peripheral error, wait timeout and a two-cycle AHB ERROR response.
module ahb_multi_bridge #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned N_SLV    = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                           h_clk,
    input  logic                           h_resetn,
    input  logic [31:0]                    h_addr,
    input  logic [2:0]                     h_burst,
    input  logic [2:0]                     h_size,
    input  logic [1:0]                     h_trans,
    input  logic                           h_write,
    input  logic [DATA_W/8-1:0]            h_wstrb,
    input  logic [DATA_W-1:0]              h_wdata,
    output logic [DATA_W-1:0]              h_rdata,
    output logic                           h_ready,
    output logic                           h_resp,
    input  logic [N_SLV*(32-OFFSET_W)-1:0] base_addr,
    output logic [N_SLV-1:0]               p_sel,
    output logic                           p_enable,
    output logic                           p_write,
    output logic [OFFSET_W-1:0]            p_offset,
    output logic [DATA_W/8-1:0]            p_strb,
    output logic [DATA_W-1:0]              p_wdata,
    input  logic [N_SLV*DATA_W-1:0]        p_rdata,
    input  logic [N_SLV-1:0]               p_ready,
    input  logic [N_SLV-1:0]               p_slverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB_W  = $clog2(STRB_W);
    localparam int unsigned BASE_W = 32 - OFFSET_W;
    localparam int unsigned SEL_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_ERR1   = 3'd3;
    localparam logic [2:0] S_ERR2   = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [N_SLV-1:0]    p_sel_q, p_sel_d;
    logic                p_enable_q, p_enable_d;
    logic                p_write_q, p_write_d;
    logic [OFFSET_W-1:0] p_offset_q, p_offset_d;
    logic [STRB_W-1:0]   p_strb_q, p_strb_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

    logic              hit;
    logic [SEL_W-1:0]  hit_idx;
    logic [STRB_W-1:0] lane_mask;
    logic              dec_err;
    int unsigned       lo;
    int unsigned       nbytes;
    logic              rdy;
    logic              slverr;
    logic              tmo;
    logic              accept;
    logic              unused_ok;

    // Address-phase decode: window hit (lowest index wins), size/alignment checks, lane mask
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        lane_mask = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (!hit && (h_addr[31:OFFSET_W] == base_addr[i*BASE_W +: BASE_W])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
        lo     = 32'(h_addr[LSB_W-1:0]);
        nbytes = 32'd1 << h_size;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            lane_mask[b] = (b >= lo) && (b < lo + nbytes);
        end
        dec_err = !hit || (32'(h_size) > LSB_W) || ((lo & (nbytes - 32'd1)) != 32'd0);
    end

    assign rdy    = p_ready[sel_q];
    assign slverr = p_slverr[sel_q];
    // Timeout fires on the TIMEOUT-th ACCESS cycle that is still waiting
    assign tmo    = (TIMEOUT != 0) && (state_q == S_ACCESS) && !rdy
                    && ((32'(wait_cnt_q) + 32'd1) >= TIMEOUT);

    // AHB data-phase response
    always_comb begin
        h_ready = 1'b1;
        h_resp  = 1'b0;
        h_rdata = '0;
        case (state_q)
            S_SETUP: h_ready = 1'b0;
            S_ACCESS: begin
                h_ready = rdy && !slverr && !tmo;
                h_resp  = (rdy && slverr) || tmo;
                h_rdata = p_rdata[32'(sel_q)*DATA_W +: DATA_W];
            end
            S_ERR1: begin
                h_ready = 1'b0;
                h_resp  = 1'b1;
            end
            S_ERR2: h_resp = 1'b1;
            default: ;
        endcase
    end

    assign accept = h_ready && h_trans[1];

    // Next state and peripheral-side controls
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        p_write_d  = p_write_q;
        p_offset_d = p_offset_q;
        p_strb_d   = p_strb_q;
        wait_cnt_d = wait_cnt_q;
        p_enable_d = 1'b0;
        p_sel_d    = '0;
        case (state_q)
            S_IDLE, S_ERR2: state_d = S_IDLE;
            S_SETUP: begin
                state_d    = S_ACCESS;
                wait_cnt_d = '0;
            end
            S_ACCESS: begin
                if (h_resp) begin
                    state_d = S_ERR2;
                end else if (rdy) begin
                    state_d = S_IDLE;
                end
                if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // h_ready is only high in states that may take a new address, so this overrides safely
        if (accept) begin
            if (dec_err) begin
                state_d = S_ERR1;
            end else begin
                state_d    = S_SETUP;
                sel_d      = hit_idx;
                p_write_d  = h_write;
                p_offset_d = h_addr[OFFSET_W-1:0];
                p_strb_d   = h_write ? (lane_mask & h_wstrb) : lane_mask;
            end
        end
        p_enable_d = (state_d == S_ACCESS);
        if ((state_d == S_SETUP) || (state_d == S_ACCESS)) begin
            p_sel_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            p_sel_q    <= '0;
            p_enable_q <= 1'b0;
            p_write_q  <= 1'b0;
            p_offset_q <= '0;
            p_strb_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            p_sel_q    <= p_sel_d;
            p_enable_q <= p_enable_d;
            p_write_q  <= p_write_d;
            p_offset_q <= p_offset_d;
            p_strb_q   <= p_strb_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign p_sel     = p_sel_q;
    assign p_enable  = p_enable_q;
    assign p_write   = p_write_q;
    assign p_offset  = p_offset_q;
    assign p_strb    = p_strb_q;
    assign p_wdata   = h_wdata;
    // Burst type plays no part in decode; every beat stands alone
    assign unused_ok = ^h_burst;

endmodule

// File: tb/tb_ahb_multi_bridge.sv
// Directed bench for ahb_multi_bridge: 32-bit data, 4 windows, TIMEOUT=4.
module tb_ahb_multi_bridge;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned N_SLV    = 4;
    localparam int unsigned TIMEOUT  = 4;

    logic                           h_clk;
    logic                           h_resetn;
    logic [31:0]                    h_addr;
    logic [2:0]                     h_burst;
    logic [2:0]                     h_size;
    logic [1:0]                     h_trans;
    logic                           h_write;
    logic [DATA_W/8-1:0]            h_wstrb;
    logic [DATA_W-1:0]              h_wdata;
    logic [DATA_W-1:0]              h_rdata;
    logic                           h_ready;
    logic                           h_resp;
    logic [N_SLV*(32-OFFSET_W)-1:0] base_addr;
    logic [N_SLV-1:0]               p_sel;
    logic                           p_enable;
    logic                           p_write;
    logic [OFFSET_W-1:0]            p_offset;
    logic [DATA_W/8-1:0]            p_strb;
    logic [DATA_W-1:0]              p_wdata;
    logic [N_SLV*DATA_W-1:0]        p_rdata;
    logic [N_SLV-1:0]               p_ready;
    logic [N_SLV-1:0]               p_slverr;

    int checks  = 0;
    int errors  = 0;
    int acc_cnt = 0;

    ahb_multi_bridge #(
        .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .N_SLV(N_SLV), .TIMEOUT(TIMEOUT)
    ) dut (
        .h_clk(h_clk), .h_resetn(h_resetn), .h_addr(h_addr), .h_burst(h_burst),
        .h_size(h_size), .h_trans(h_trans), .h_write(h_write), .h_wstrb(h_wstrb),
        .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ready(h_ready), .h_resp(h_resp),
        .base_addr(base_addr), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write),
        .p_offset(p_offset), .p_strb(p_strb), .p_wdata(p_wdata), .p_rdata(p_rdata),
        .p_ready(p_ready), .p_slverr(p_slverr)
    );

    initial h_clk = 1'b0;
    always #5 h_clk = ~h_clk;

    // Completed OKAY peripheral accesses, sampled mid-cycle
    always @(negedge h_clk) begin
        if (h_resetn && p_enable && h_ready && !h_resp) acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge h_clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                              input logic [3:0] st, input logic [1:0] tr);
        h_addr  = a;
        h_size  = sz;
        h_write = wr;
        h_wstrb = st;
        h_trans = tr;
    endtask

    // Issue one beat that must decode-error; caller is in a state with h_ready=1
    task automatic err_seq(input string tag, input logic [31:0] a, input logic [2:0] sz);
        addr_phase(a, sz, 1'b0, 4'hF, 2'b10);
        tick();
        h_trans = 2'b00;
        #1;
        check_eq({tag, "_e1_psel"}, 64'(p_sel), 64'h0);
        check_eq({tag, "_e1_resp"}, 64'(h_resp), 64'h1);
        check_eq({tag, "_e1_rdy"}, 64'(h_ready), 64'h0);
        tick();
        check_eq({tag, "_e2_resp"}, 64'(h_resp), 64'h1);
        check_eq({tag, "_e2_rdy"}, 64'(h_ready), 64'h1);
        check_eq({tag, "_e2_pen"}, 64'(p_enable), 64'h0);
        tick();
        check_eq({tag, "_idle_resp"}, 64'(h_resp), 64'h0);
        check_eq({tag, "_idle_rdy"}, 64'(h_ready), 64'h1);
    endtask

    initial begin
        h_resetn  = 1'b0;
        h_burst   = 3'b000;
        h_wdata   = '0;
        addr_phase(32'h0, 3'd0, 1'b0, 4'h0, 2'b00);
        base_addr = {26'h10, 26'h30, 26'h10, 26'h20};
        p_rdata   = {32'h33333333, 32'h22222222, 32'hAA000000, 32'h11111111};
        p_ready   = 4'hF;
        p_slverr  = 4'h0;
        #12;
        check_eq("rst_hready", 64'(h_ready), 64'h1);
        check_eq("rst_hresp", 64'(h_resp), 64'h0);
        check_eq("rst_hrdata", 64'(h_rdata), 64'h0);
        check_eq("rst_psel", 64'(p_sel), 64'h0);
        check_eq("rst_pen", 64'(p_enable), 64'h0);
        check_eq("rst_pwrite", 64'(p_write), 64'h0);
        check_eq("rst_poff", 64'(p_offset), 64'h0);
        check_eq("rst_pstrb", 64'(p_strb), 64'h0);
        tick();
        h_resetn = 1'b1;

        // Word write to window 1 (window 3 shares the base; lowest index must win)
        addr_phase(32'h404, 3'd2, 1'b1, 4'hF, 2'b10);
        h_wdata = 32'hDEADBEEF;
        #1;
        check_eq("wr_idle_rdy", 64'(h_ready), 64'h1);
        tick();
        h_trans = 2'b00;
        #1;
        check_eq("wr_setup_psel", 64'(p_sel), 64'h2);
        check_eq("wr_setup_pen", 64'(p_enable), 64'h0);
        check_eq("wr_setup_rdy", 64'(h_ready), 64'h0);
        check_eq("wr_setup_poff", 64'(p_offset), 64'h04);
        check_eq("wr_setup_pstrb", 64'(p_strb), 64'hF);
        check_eq("wr_setup_pwrite", 64'(p_write), 64'h1);
        tick();
        check_eq("wr_acc_pen", 64'(p_enable), 64'h1);
        check_eq("wr_acc_psel", 64'(p_sel), 64'h2);
        check_eq("wr_acc_rdy", 64'(h_ready), 64'h1);
        check_eq("wr_acc_resp", 64'(h_resp), 64'h0);
        check_eq("wr_acc_pwdata", 64'(p_wdata), 64'hDEADBEEF);
        tick();
        check_eq("wr_done_psel", 64'(p_sel), 64'h0);
        check_eq("wr_done_pen", 64'(p_enable), 64'h0);

        // Byte read at 0x403 with three wait cycles
        addr_phase(32'h403, 3'd0, 1'b0, 4'hF, 2'b10);
        tick();
        h_trans = 2'b00;
        p_ready = 4'h0;
        #1;
        check_eq("rd_setup_rdy", 64'(h_ready), 64'h0);
        check_eq("rd_setup_pstrb", 64'(p_strb), 64'h8);
        check_eq("rd_setup_pwrite", 64'(p_write), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("rd_wait_rdy", 64'(h_ready), 64'h0);
            check_eq("rd_wait_resp", 64'(h_resp), 64'h0);
        end
        tick();
        p_ready = 4'hF;
        #1;
        check_eq("rd_done_rdy", 64'(h_ready), 64'h1);
        check_eq("rd_done_resp", 64'(h_resp), 64'h0);
        check_eq("rd_done_rdata", 64'(h_rdata), 64'hAA000000);
        tick();
        check_eq("rd_idle_rdata", 64'(h_rdata), 64'h0);

        // Decode errors: unmapped, misaligned word, oversize transfer
        err_seq("unmapped", 32'hFFFF0000, 3'd2);
        err_seq("misalign", 32'h402, 3'd2);
        err_seq("size3", 32'h400, 3'd3);

        // Halfword write: lane mask 4'b1100 ANDed with strobes 4'b0101
        addr_phase(32'h406, 3'd1, 1'b1, 4'b0101, 2'b10);
        tick();
        h_trans = 2'b00;
        #1;
        check_eq("hw_pstrb", 64'(p_strb), 64'h4);
        check_eq("hw_poff", 64'(p_offset), 64'h06);
        tick();
        tick();

        // INCR4 burst with a BUSY beat
        acc_cnt = 0;
        h_burst = 3'b011;
        addr_phase(32'h400, 3'd2, 1'b1, 4'hF, 2'b10);
        tick();
        addr_phase(32'h404, 3'd2, 1'b1, 4'hF, 2'b11);
        #1;
        check_eq("b0_setup_poff", 64'(p_offset), 64'h00);
        check_eq("b0_setup_rdy", 64'(h_ready), 64'h0);
        tick();
        check_eq("b0_acc_rdy", 64'(h_ready), 64'h1);
        tick();
        addr_phase(32'h408, 3'd2, 1'b1, 4'hF, 2'b01);
        #1;
        check_eq("b1_setup_poff", 64'(p_offset), 64'h04);
        tick();
        check_eq("b1_acc_rdy", 64'(h_ready), 64'h1);
        check_eq("b1_acc_pen", 64'(p_enable), 64'h1);
        tick();
        addr_phase(32'h408, 3'd2, 1'b1, 4'hF, 2'b11);
        #1;
        check_eq("busy_rdy", 64'(h_ready), 64'h1);
        check_eq("busy_resp", 64'(h_resp), 64'h0);
        check_eq("busy_psel", 64'(p_sel), 64'h0);
        check_eq("busy_poff", 64'(p_offset), 64'h04);
        tick();
        addr_phase(32'h40C, 3'd2, 1'b1, 4'hF, 2'b11);
        #1;
        check_eq("b2_setup_poff", 64'(p_offset), 64'h08);
        tick();
        check_eq("b2_acc_rdy", 64'(h_ready), 64'h1);
        tick();
        h_trans = 2'b00;
        #1;
        check_eq("b3_setup_poff", 64'(p_offset), 64'h0C);
        tick();
        check_eq("b3_acc_rdy", 64'(h_ready), 64'h1);
        tick();
        check_eq("burst_accesses", 64'(acc_cnt), 64'd4);
        h_burst = 3'b000;

        // Peripheral error from window 2
        addr_phase(32'hC08, 3'd2, 1'b0, 4'hF, 2'b10);
        p_slverr = 4'b0100;
        tick();
        h_trans = 2'b00;
        #1;
        check_eq("se_setup_psel", 64'(p_sel), 64'h4);
        tick();
        check_eq("se_acc_resp", 64'(h_resp), 64'h1);
        check_eq("se_acc_rdy", 64'(h_ready), 64'h0);
        tick();
        check_eq("se_err2_resp", 64'(h_resp), 64'h1);
        check_eq("se_err2_rdy", 64'(h_ready), 64'h1);
        check_eq("se_err2_psel", 64'(p_sel), 64'h0);
        p_slverr = 4'h0;
        tick();

        // Timeout on window 0: ERROR on the 4th ACCESS cycle
        addr_phase(32'h800, 3'd2, 1'b1, 4'hF, 2'b10);
        p_ready = 4'h0;
        tick();
        h_trans = 2'b00;
        #1;
        check_eq("to_setup_psel", 64'(p_sel), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("to_wait_rdy", 64'(h_ready), 64'h0);
            check_eq("to_wait_resp", 64'(h_resp), 64'h0);
        end
        tick();
        check_eq("to_err_resp", 64'(h_resp), 64'h1);
        check_eq("to_err_rdy", 64'(h_ready), 64'h0);
        tick();
        check_eq("to_err2_resp", 64'(h_resp), 64'h1);
        check_eq("to_err2_rdy", 64'(h_ready), 64'h1);
        check_eq("to_err2_psel", 64'(p_sel), 64'h0);
        p_ready = 4'hF;
        tick();

        // Asynchronous reset during ACCESS
        addr_phase(32'h404, 3'd2, 1'b0, 4'hF, 2'b10);
        p_ready = 4'h0;
        tick();
        h_trans = 2'b00;
        tick();
        check_eq("ar_acc_pen", 64'(p_enable), 64'h1);
        check_eq("ar_acc_rdata", 64'(h_rdata), 64'hAA000000);
        h_resetn = 1'b0;
        #1;
        check_eq("ar_psel", 64'(p_sel), 64'h0);
        check_eq("ar_pen", 64'(p_enable), 64'h0);
        check_eq("ar_poff", 64'(p_offset), 64'h0);
        check_eq("ar_pstrb", 64'(p_strb), 64'h0);
        check_eq("ar_rdy", 64'(h_ready), 64'h1);
        check_eq("ar_resp", 64'(h_resp), 64'h0);
        check_eq("ar_rdata", 64'(h_rdata), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
